ni_packetizer: RTL and testbench

Network-interface injection stage. It queues 32-bit write requests from the local MIPS core and serialises each one into a 5-flit packet on the 8-bit NI flit port of the router switch controller. It sits directly upstream of the controller's NI input. It drives `flit_out`/`flit_valid` and obeys the controller's `noc_ready` grant.

---
 rtl/ni_packetizer.sv | 140 ++++++++++++++
 tb/tb_ni_packetizer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/ni_packetizer.sv
// Queues 32-bit core write requests and serialises each into a 5-flit packet ({HEAD,dest} + 4 data bytes, MSB first).
// Latency: head flit valid one cycle after a push into an empty FIFO; 6 cycles per packet with noc_ready held high.
// Backpressure: noc_ready=0 holds the current flit; the FIFO absorbs requests and req_ready drops when it is full.
module ni_packetizer #(
   parameter logic [5:0] HEAD  = 6'b101111,
   parameter int         DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  current_node,
   input  logic        req_valid,
   input  logic [1:0]  req_dest,
   input  logic [31:0] req_data,
   output logic        req_ready,
   input  logic        noc_ready,
   output logic [7:0]  flit_out,
   output logic        flit_valid,
   output logic        self_drop,
   output logic        busy
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HDR  = 2'd1,
      PAY  = 2'd2
   } state_t;

   state_t        state;
   logic [33:0]   mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic          full;
   logic          empty;
   logic          push;
   logic          pop;
   logic [1:0]    head_dest;
   logic [31:0]   head_data;
   logic [31:0]   sh_reg;
   logic [1:0]    idx;
   logic          xfer;

   assign full      = (count == (AW + 1)'(DEPTH));
   assign empty     = (count == '0);
   assign req_ready = !full;
   assign push      = req_valid && !full;
   // Every IDLE cycle with a queued entry consumes it, either as a packet or a self-drop.
   assign pop       = (state == IDLE) && !empty;
   assign head_dest = mem[rd_ptr][33:32];
   assign head_data = mem[rd_ptr][31:0];
   assign xfer      = flit_valid && noc_ready;
   assign busy      = !empty || (state != IDLE);

   // Request storage; contents need no reset since pointers/count gate every read.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= {req_dest, req_data};
      end
   end

   // FIFO pointers and occupancy; simultaneous push and pop leaves count unchanged.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Packet serialiser: pop decision in IDLE, then header and four payload bytes, each held until accepted.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         sh_reg     <= '0;
         idx        <= '0;
         flit_out   <= '0;
         flit_valid <= 1'b0;
         self_drop  <= 1'b0;
      end else begin
         self_drop <= 1'b0;
         case (state)
            IDLE: begin
               flit_out   <= '0;
               flit_valid <= 1'b0;
               if (!empty) begin
                  if (head_dest == current_node) begin
                     self_drop <= 1'b1;
                  end else begin
                     sh_reg     <= head_data;
                     flit_out   <= {HEAD, head_dest};
                     flit_valid <= 1'b1;
                     state      <= HDR;
                  end
               end
            end
            HDR: begin
               if (xfer) begin
                  flit_out <= sh_reg[31:24];
                  idx      <= '0;
                  state    <= PAY;
               end
            end
            PAY: begin
               if (xfer) begin
                  if (idx == 2'd3) begin
                     flit_out   <= '0;
                     flit_valid <= 1'b0;
                     state      <= IDLE;
                  end else begin
                     // The next byte sits just below the one being shifted out.
                     sh_reg   <= {sh_reg[23:0], 8'h00};
                     flit_out <= sh_reg[23:16];
                     idx      <= idx + 1'b1;
                  end
               end
            end
            default: begin
               flit_out   <= '0;
               flit_valid <= 1'b0;
               state      <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ni_packetizer.sv
// Scoreboard bench for ni_packetizer: stimulus queues expected flits/drops, a negedge monitor checks them.
// Also checks reset values, head latency, stall holding, FIFO full behaviour, packet spacing and mid-packet reset.
// The run ends with a single summary line.
module tb_ni_packetizer;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  current_node;
   logic        req_valid;
   logic [1:0]  req_dest;
   logic [31:0] req_data;
   logic        req_ready;
   logic        noc_ready;
   logic [7:0]  flit_out;
   logic        flit_valid;
   logic        self_drop;
   logic        busy;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   // {is_drop, is_head, byte}
   logic [9:0] exp_q[$];
   int         head_cyc[$];
   logic       stall_v = 1'b0;
   logic [7:0] stall_f = 8'h00;

   ni_packetizer #(.HEAD(6'b101111), .DEPTH(4)) dut (
      .clk(clk), .rst(rst), .current_node(current_node),
      .req_valid(req_valid), .req_dest(req_dest), .req_data(req_data),
      .req_ready(req_ready), .noc_ready(noc_ready),
      .flit_out(flit_out), .flit_valid(flit_valid),
      .self_drop(self_drop), .busy(busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      total++;
      if (act !== exp_v) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp_v, $time);
      end
   endtask

   // Offer one request, wait for acceptance, and record its expected output.
   task automatic push(input logic [1:0] d, input logic [31:0] w);
      int k;
      req_valid = 1'b1;
      req_dest  = d;
      req_data  = w;
      k = 0;
      while (!req_ready && k < 300) begin
         @(posedge clk); #1;
         k++;
      end
      chk("push_ready", req_ready, 1);
      if (d == current_node) begin
         exp_q.push_back({2'b10, 8'h00});
      end else begin
         exp_q.push_back({2'b01, 6'b101111, d});
         exp_q.push_back({2'b00, w[31:24]});
         exp_q.push_back({2'b00, w[23:16]});
         exp_q.push_back({2'b00, w[15:8]});
         exp_q.push_back({2'b00, w[7:0]});
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
   endtask

   task automatic drain();
      int k;
      k = 0;
      while ((exp_q.size() != 0 || busy) && k < 600) begin
         @(posedge clk); #1;
         k++;
      end
      chk("drain_queue", exp_q.size(), 0);
      chk("drain_busy", busy, 0);
   endtask

   // Monitor: transfers are judged at the negedge preceding the accepting edge.
   always @(negedge clk) begin
      logic [9:0] e;
      if (rst) begin
         stall_v = 1'b0;
      end else begin
         if (stall_v) begin
            chk("hold_valid", flit_valid, 1);
            chk("hold_flit", flit_out, stall_f);
         end
         if (self_drop) begin
            if (exp_q.size() == 0) begin
               total++; bad++;
               $display("FAIL unexpected_drop: got self_drop=1 expected none");
            end else begin
               e = exp_q.pop_front();
               chk("drop_kind", e[9], 1);
            end
         end
         if (flit_valid && noc_ready) begin
            if (exp_q.size() == 0) begin
               total++; bad++;
               $display("FAIL unexpected_flit: got %0h expected none", flit_out);
            end else begin
               e = exp_q.pop_front();
               chk("flit_kind", e[9], 0);
               chk("flit_dat", flit_out, e[7:0]);
               if (e[8]) head_cyc.push_back(cyc);
            end
         end
         stall_v = flit_valid && !noc_ready;
         stall_f = flit_out;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] pat;
      pat = 4'b1001;
      rst = 1'b1; current_node = 2'b00; noc_ready = 1'b1;
      req_valid = 1'b1; req_dest = 2'b10; req_data = 32'h11111111;

      // Reset state, with a push attempted during reset.
      #3;
      chk("rst_flit_valid", flit_valid, 0);
      chk("rst_flit_out", flit_out, 0);
      chk("rst_self_drop", self_drop, 0);
      chk("rst_busy", busy, 0);
      chk("rst_req_ready", req_ready, 1);
      @(posedge clk); @(posedge clk); #1;
      chk("rst_busy_after_push", busy, 0);
      req_valid = 1'b0;
      rst = 1'b0;
      @(posedge clk); #1;
      chk("post_rst_busy", busy, 0);
      chk("post_rst_valid", flit_valid, 0);

      // Basic packet and latency.
      push(2'b10, 32'hDEADBEEF);
      chk("lat_pre", flit_valid, 0);
      @(posedge clk); #1;
      chk("lat_head_vld", flit_valid, 1);
      chk("lat_head", flit_out, 8'hBE);
      repeat (5) @(posedge clk);
      #1;
      chk("end_vld", flit_valid, 0);
      chk("end_flit", flit_out, 0);
      chk("end_busy", busy, 0);
      drain();

      // noc_ready toggling 1,0,0,1.
      push(2'b10, 32'h12345678);
      for (int i = 0; i < 40; i++) begin
         noc_ready = pat[i % 4];
         @(posedge clk); #1;
      end
      noc_ready = 1'b1;
      drain();

      // Self-addressed request dropped, then a normal packet.
      current_node = 2'b01;
      push(2'b01, 32'hCAFEF00D);
      push(2'b11, 32'h0BADC0DE);
      drain();
      current_node = 2'b00;

      // FIFO fill while stalled: one entry in flight plus DEPTH queued.
      noc_ready = 1'b0;
      push(2'b01, 32'hA0A1A2A3);
      push(2'b10, 32'hB0B1B2B3);
      push(2'b11, 32'hC0C1C2C3);
      push(2'b01, 32'hD0D1D2D3);
      chk("ready_after_4", req_ready, 1);
      push(2'b10, 32'hE0E1E2E3);
      chk("ready_after_5", req_ready, 0);
      req_valid = 1'b1; req_dest = 2'b11; req_data = 32'hF0F1F2F3;
      repeat (3) @(posedge clk);
      #1;
      chk("held_off", req_ready, 0);
      chk("busy_full", busy, 1);
      head_cyc.delete();
      noc_ready = 1'b1;
      push(2'b11, 32'hF0F1F2F3);
      drain();
      chk("head_count", head_cyc.size(), 6);
      for (int i = 1; i < head_cyc.size(); i++) begin
         chk("head_spacing", head_cyc[i] - head_cyc[i-1], 6);
      end

      // Zero payload still valid flits.
      push(2'b01, 32'h00000000);
      drain();

      // Reset after the second payload flit.
      push(2'b10, 32'h13579BDF);
      repeat (4) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      chk("midrst_valid", flit_valid, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_lost", exp_q.size(), 2);
      exp_q.delete();
      @(posedge clk); #1;
      rst = 1'b0;
      push(2'b11, 32'hA5A55A5A);
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
